fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Upstream fetch stage for the single-cycle MIPS datapath. Owns the PC, issues word reads to an
//  instruction memory with variable latency (req/ack), and buffers the returned words with their PCs
//  in a small queue. Presents one instruction per cycle to the decode/execute stage (valid/ready).
//  Resolves beq redirects from Branch & zero_flag, flushing wrong-path words.
// PARAMETERS
//  N         32   data/address width
//  DEPTH     2    queue entries {pc,instr}, power of 2
//  RESET_PC  0    first fetch address after reset
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   asynchronous, active-high reset
//  imem_req         out  1   read request to instruction memory
//  imem_addr        out  N   byte address of request, [1:0]==0
//  imem_ack         in   1   response valid; may coincide with the req cycle
//  imem_data        in   N   instruction word, valid with imem_ack
//  instr_valid      out  1   instr/instr_pc hold a valid entry (queue head)
//  instr            out  N   current instruction
//  instr_pc         out  N   PC of current instruction
//  instr_ready      in   1   consumer accepts head this cycle
//  Branch           in   1   control-unit branch flag for current instruction
//  zero_flag        in   1   ALU zero flag for current instruction
//  immediate        in   N   sign-extended immediate of current instruction
// BEHAVIOUR
//  Reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, queue empty,
//   fetch_pc=RESET_PC, state IDLE. Asserting rst at any time aborts everything the same way; a
//   late imem_ack for a pre-reset request is ignored.
//  accept = instr_valid & instr_ready. taken = accept & Branch & zero_flag.
//  target = instr_pc + 4 + (immediate << 2), modulo 2^N; sequential PC = fetch_pc + 4, wraps 0xFFFFFFFC->0.
//  FSM:
//   IDLE : imem_req=0. Go WAIT when free slots (DEPTH - count, after this cycle's pop) >= 1.
//   WAIT : imem_req=1, imem_addr=fetch_pc, both held stable until imem_ack.
//          ack & !taken -> push {fetch_pc, imem_data}, fetch_pc+=4; WAIT if a slot remains after push, else IDLE.
//          !ack & taken -> DROP. ack & taken -> discard data, IDLE.
//   DROP : imem_req held 1 at old address until ack; ack -> discard data, IDLE. No push in DROP.
//  taken (any state): flush queue, fetch_pc <= target same edge; instr_valid=0 next cycle.
//  Max one outstanding request; never issue when the push would overflow. Push and pop in the
//   same cycle are legal; count unchanged. Pop from empty queue impossible (accept needs valid).
//  Latency: zero-wait memory (ack in req cycle) -> instr_valid 1 cycle after the ack edge; first
//   request asserted in the first cycle after rst deasserts. Steady state, zero-wait memory and
//   instr_ready=1: one instruction per cycle. Taken branch bubble: >=2 cycles.
//  Branch/zero_flag/immediate are ignored when !accept.
//  Outputs instr/instr_pc are the queue head, registered; hold value when !instr_valid.
// STRUCTURE
//  fetch_defs.vh (shared include): FSM encodings IDLE=2'd0, WAIT=2'd1, DROP=2'd2;
//   INSTR_BYTES=4; RESET_PC default.
//  Sub-module fetch_queue: DEPTH-entry FIFO of {pc,instr}, push/pop/flush, count, full/empty;
//   flush dominates push in the same cycle.
//  Top: PC register, FSM, target adder, glue. Target ~120-250 lines total.
// TESTING
//  1 Reset, zero-wait mem returning 0x8C410001 @0: first req @0 in cycle 1 after rst low; valid
//    next cycle with instr_pc=0; 4 sequential words -> pcs 0,4,8,12 on consecutive cycles.
//  2 instr_ready=0 for 5 cycles: queue fills to DEPTH=2, imem_req drops to 0; head unchanged;
//    ready=1 -> drains in order, no loss or duplicate.
//  3 beq at pc=0x10, immediate=1, Branch=zero_flag=1 on accept: queue flushed, next req addr=0x18,
//    next valid instr_pc=0x18; wrong-path pc=0x14 never presented.
//  4 3-cycle memory, taken branch while request outstanding: FSM enters DROP, late data discarded,
//    next request to target; ack+taken in same cycle -> data discarded, no push.
//  5 fetch_pc=0xFFFFFFFC: next sequential addr 0x00000000; immediate=-2 (0xFFFFFFFE) at pc=8 -> target=4.
//  6 rst pulsed mid-WAIT with a later ack: outputs return to reset values, stale ack ignored,
//    fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_prefetch_unit_pkg: shared fetch FSM encoding and fetch constants
package fetch_prefetch_unit_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// fetch_prefetch_unit_queue: DEPTH-entry shift FIFO of {pc,instr}; slot 0 is the head and keeps its value when emptied
module fetch_prefetch_unit_queue #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  push_pc_i,
  input  logic [W-1:0]  push_instr_i,
  output logic [W-1:0]  head_pc_o,
  output logic [W-1:0]  head_instr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [2*W-1:0] mem_q [DEPTH];
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  keep;
  assign keep = count_q - CW'(pop_i);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      count_q <= keep + CW'(push_i);
      for (int i = 0; i < DEPTH - 1; i++)
        if (pop_i && i + 1 < int'(count_q)) mem_q[i] <= mem_q[i+1];
      for (int i = 0; i < DEPTH; i++)
        if (push_i && i == int'(keep)) mem_q[i] <= {push_pc_i, push_instr_i};
    end
  assign head_pc_o    = mem_q[0][2*W-1:W];
  assign head_instr_o = mem_q[0][W-1:0];
  assign count_o      = count_q;
  assign full_o       = count_q == CW'(DEPTH);
  assign empty_o      = count_q == '0;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner issuing req/ack imem reads into a {pc,instr} queue with beq redirect and flush
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int N = 32,
  parameter int DEPTH = 2,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_data,
  output logic         instr_valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  input  logic         instr_ready,
  input  logic         Branch,
  input  logic         zero_flag,
  input  logic [N-1:0] immediate
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_e  state_q, state_d;
  logic [N-1:0]  fetch_pc_q, fetch_pc_d, drop_addr_q, drop_addr_d, target;
  logic [CW-1:0] count;
  logic          full, empty, accept, taken, push, room_after_push;
  assign accept          = instr_valid & instr_ready;
  assign taken           = accept & Branch & zero_flag;
  assign target          = instr_pc + N'(INSTR_BYTES) + (immediate << 2);
  assign instr_valid     = !empty;
  assign room_after_push = count - CW'(accept) + CW'(1) < CW'(DEPTH);
  // DROP keeps presenting the abandoned address while fetch_pc already holds the branch target
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    imem_req    = state_q != IDLE;
    imem_addr   = state_q == DROP ? drop_addr_q : fetch_pc_q;
    case (state_q)
      IDLE: state_d = (!full || accept) ? WAIT : IDLE;
      WAIT: begin
        push        = imem_ack && !taken;
        fetch_pc_d  = push ? fetch_pc_q + N'(INSTR_BYTES) : fetch_pc_q;
        drop_addr_d = taken ? fetch_pc_q : drop_addr_q;
        state_d     = push ? (room_after_push ? WAIT : IDLE) : taken ? (imem_ack ? IDLE : DROP) : WAIT;
      end
      DROP: state_d = imem_ack ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
    if (taken) fetch_pc_d = target;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  fetch_prefetch_unit_queue #(.W(N), .DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (accept),
    .flush_i      (taken),
    .push_pc_i    (fetch_pc_q),
    .push_instr_i (imem_data),
    .head_pc_o    (instr_pc),
    .head_instr_o (instr),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );
endmodule
